// File: rtl/mat_pkg.sv
// Shared definitions for the matrix block family.
//   - state_t : pass sequencing states (IDLE, RUN, DONE)
//   - MAT_M, MAT_P : default matrix shape (A is MAT_M x MAT_P)
//   - N_ELEM  : element count of the default shape
//   - IDX_W   : width of element addresses and output indices
package mat_pkg;

  localparam int MAT_M  = 3;
  localparam int MAT_P  = 3;
  localparam int N_ELEM = MAT_M * MAT_P;
  localparam int IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mat_regfile.sv
// Element storage for one matrix: N words of DATA_WIDTH bits.
// Ports:
//   clk, rst     : clock, asynchronous active-low clear of every word
//   wen, waddr   : synchronous write strobe and address (ignored if out of range)
//   wdata        : write data
//   raddr, rdata : combinational read port
module mat_regfile
  import mat_pkg::*;
#(
  parameter int N          = N_ELEM,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [N];

  // NOTE: this storage is deliberately cleared by reset (the block must come
  // up as an all-zero matrix); that forces flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (wen && (int'(waddr) < N)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mat_transpose_3x3.sv
// Streaming transposer: a host loads A (M x P, row-major) element by element
// while idle; on start the block emits C = A^T (P x M) one element per cycle,
// each tagged with its row-major C index.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   start           : begin a pass (only honoured in IDLE)
//   a_in/a_addr/a_wen : A write port (only honoured in IDLE, a_addr < M*P)
//   c_out, i_count_out, c_valid : registered output element, its index, strobe
//   done            : one-cycle pulse after the last element
//   busy            : present only when MAT_TRANSPOSE_BUSY_EN is defined;
//                     high while the pass is in RUN or DONE
module mat_transpose_3x3
  import mat_pkg::*;
#(
  parameter int M          = MAT_M,
  parameter int P          = MAT_P,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] a_in,
  input  logic        [IDX_W-1:0]      a_addr,
  input  logic                         a_wen,
  output logic signed [DATA_WIDTH-1:0] c_out,
  output logic                         c_valid,
  output logic                         done,
  output logic        [IDX_W-1:0]      i_count_out
`ifdef MAT_TRANSPOSE_BUSY_EN
  ,
  output logic                         busy
`endif
);

  localparam int NE = M * P;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        cnt_q;   // C index of the element read this cycle
  logic [IDX_W-1:0]        row_q;   // C row    = cnt_q / M
  logic [IDX_W-1:0]        col_q;   // C column = cnt_q % M
  logic [IDX_W-1:0]        rd_addr;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   rd_data;

  // Loads are only accepted between passes so a running pass sees stable data.
  assign wr_en = a_wen && (state_q == IDLE) && (int'(a_addr) < NE);

  // C[r][c] = A[c][r]; A is stored row-major with P columns.
  assign rd_addr = IDX_W'(int'(col_q) * P + int'(row_q));

  mat_regfile #(
    .N          (NE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .wen   (wr_en),
    .waddr (a_addr),
    .wdata (a_in),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (int'(cnt_q) == NE - 1) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and counter registers; outputs lag the state by one edge so the
  // element read in RUN cycle k appears after the following edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_out       <= '0;
      c_valid     <= 1'b0;
      done        <= 1'b0;
      i_count_out <= '0;
      cnt_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
    end else begin
      c_valid <= 1'b0;
      done    <= 1'b0;
      case (state_q)
        RUN: begin
          c_out       <= rd_data;
          c_valid     <= 1'b1;
          i_count_out <= cnt_q;
          cnt_q       <= cnt_q + IDX_W'(1);
          if (int'(col_q) == M - 1) begin
            col_q <= '0;
            row_q <= row_q + IDX_W'(1);
          end else begin
            col_q <= col_q + IDX_W'(1);
          end
        end
        DONE: done <= 1'b1;
        default: begin
          cnt_q <= '0;
          row_q <= '0;
          col_q <= '0;
        end
      endcase
    end
  end

`ifdef MAT_TRANSPOSE_BUSY_EN
  assign busy = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_mat_transpose_3x3.sv
// Self-checking bench for mat_transpose_3x3 (3x3, 32-bit). Expected C is built
// by transposing a 2-D copy of the loaded matrix.
module tb_mat_transpose_3x3;

  localparam int M  = 3;
  localparam int P  = 3;
  localparam int DW = 32;
  localparam int N  = M * P;

  logic                 clk    = 1'b0;
  logic                 rst    = 1'b1;
  logic                 start  = 1'b0;
  logic                 a_wen  = 1'b0;
  logic signed [DW-1:0] a_in   = '0;
  logic [3:0]           a_addr = '0;
  logic signed [DW-1:0] c_out;
  logic                 c_valid;
  logic                 done;
  logic [3:0]           i_count_out;
`ifdef MAT_TRANSPOSE_BUSY_EN
  logic                 busy;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] a_model [N];
  logic [DW-1:0] c_exp   [N];

  always #5 clk = ~clk;

  mat_transpose_3x3 #(.M(M), .P(P), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a_in        (a_in),
    .a_addr      (a_addr),
    .a_wen       (a_wen),
    .c_out       (c_out),
    .c_valid     (c_valid),
    .done        (done),
    .i_count_out (i_count_out)
`ifdef MAT_TRANSPOSE_BUSY_EN
    ,
    .busy        (busy)
`endif
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic build_expected();
    logic [DW-1:0] a2 [M][P];
    logic [DW-1:0] c2 [P][M];
    for (int r = 0; r < M; r++)
      for (int c = 0; c < P; c++) a2[r][c] = a_model[r*P + c];
    for (int r = 0; r < P; r++)
      for (int c = 0; c < M; c++) c2[r][c] = a2[c][r];
    for (int r = 0; r < P; r++)
      for (int c = 0; c < M; c++) c_exp[r*M + c] = c2[r][c];
  endtask

  task automatic load_all();
    for (int i = 0; i < N; i++) begin
      a_wen  = 1'b1;
      a_addr = 4'(i);
      a_in   = a_model[i];
      step();
    end
    a_wen = 1'b0;
  endtask

  // One full pass. poke_write: attempt a write of 99 to address 4 mid-run.
  // poke_start: pulse start mid-run. chain: raise start in the done cycle.
  task automatic run_pass(input bit poke_write, input bit poke_start, input bit chain);
    build_expected();
    start = 1'b1;
    step();
    start = 1'b0;
    a_wen = 1'b0;
    check("start_edge_valid", c_valid, 1'b0);
    for (int k = 0; k < N; k++) begin
      if (poke_write && k == 2) begin
        a_wen  = 1'b1;
        a_addr = 4'd4;
        a_in   = 99;
      end
      if (poke_start && k == 3) start = 1'b1;
      step();
      a_wen = 1'b0;
      start = 1'b0;
      check($sformatf("beat%0d_valid", k), c_valid, 1'b1);
      check($sformatf("beat%0d_index", k), i_count_out, k);
      check($sformatf("beat%0d_data", k), c_out, c_exp[k]);
      check($sformatf("beat%0d_done", k), done, 1'b0);
`ifdef MAT_TRANSPOSE_BUSY_EN
      check($sformatf("beat%0d_busy", k), busy, 1'b1);
`endif
    end
    step();
    check("done_pulse", done, 1'b1);
    check("done_valid", c_valid, 1'b0);
    if (chain) begin
      start = 1'b1;
    end else begin
      step();
      check("done_clear", done, 1'b0);
      check("idle_valid", c_valid, 1'b0);
    end
  endtask

  initial begin
    // Asynchronous reset before any clock edge.
    #2 rst = 1'b0;
    #1;
    check("rst_c_out", c_out, 0);
    check("rst_valid", c_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_index", i_count_out, 0);
`ifdef MAT_TRANSPOSE_BUSY_EN
    check("rst_busy", busy, 1'b0);
`endif
    for (int i = 0; i < N; i++) a_model[i] = '0;
    step();
    step();
    rst = 1'b1;
    step();

    // A = 1..9 row-major -> 1,4,7,2,5,8,3,6,9.
    for (int i = 0; i < N; i++) a_model[i] = DW'(i + 1);
    load_all();
    run_pass(1'b0, 1'b0, 1'b0);

    // Mid-run start ignored; start in the IDLE cycle after done chains a pass.
    run_pass(1'b0, 1'b1, 1'b1);
    run_pass(1'b0, 1'b0, 1'b0);

    // Signed extremes plus random fill; a write during RUN must be dropped.
    for (int i = 0; i < N; i++) a_model[i] = $urandom;
    a_model[0] = -5;
    a_model[1] = 32'h8000_0000;
    load_all();
    run_pass(1'b1, 1'b0, 1'b0);
    run_pass(1'b0, 1'b0, 1'b0);

    // Out-of-range addresses must not disturb storage.
    a_wen  = 1'b1;
    a_addr = 4'd12;
    a_in   = $urandom;
    step();
    a_addr = 4'd15;
    a_in   = $urandom;
    step();
    a_wen = 1'b0;
    run_pass(1'b0, 1'b0, 1'b0);

    // A write on the same edge as start is visible to that pass.
    a_model[8] = $urandom;
    a_wen  = 1'b1;
    a_addr = 4'd8;
    a_in   = a_model[8];
    run_pass(1'b0, 1'b0, 1'b0);

    // Reset at beat 4: outputs drop immediately, no done, storage cleared.
    build_expected();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      step();
      check($sformatf("pre_rst_beat%0d_data", k), c_out, c_exp[k]);
    end
    #1 rst = 1'b0;
    #1;
    check("midrst_c_out", c_out, 0);
    check("midrst_valid", c_valid, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_index", i_count_out, 0);
    for (int i = 0; i < N; i++) a_model[i] = '0;
    step();
    rst = 1'b1;
    for (int k = 0; k < N + 2; k++) begin
      step();
      check("post_rst_no_done", done, 1'b0);
      check("post_rst_no_valid", c_valid, 1'b0);
    end
    run_pass(1'b0, 1'b0, 1'b0);

    // Random matrices.
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < N; i++) a_model[i] = $urandom;
      load_all();
      run_pass(1'b0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mat_transpose_3x3.md
# mat_transpose_3x3

Streaming transposer for a small signed matrix held in a local register file. A host loads an M×P matrix A element by element. On `start`, the block emits C = Aᵀ (P×M) one element per cycle, each tagged with its destination index. It sits between the tracker's matrix-load path and downstream matrix arithmetic, and it is the reference shape for the other matrix blocks.

## Interface
Reset policy: one clock; reset is asynchronous and active-low.

- `M`, default 3: rows of A and columns of C.
- `P`, default 3: columns of A and rows of C.
- `DATA_WIDTH`, default 32: element width, two's-complement signed.

Ports:
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-low reset (asserted at 0).
- `start` input 1: begin a transpose pass; sampled in IDLE only.
- `a_in` input DATA_WIDTH, signed: write data for A.
- `a_addr` input 4: row-major A index, r*P+c, valid range 0..M*P-1.
- `a_wen` input 1: write strobe for A.
- `c_out` output DATA_WIDTH, signed: current C element.
- `c_valid` output 1: `c_out` and `i_count_out` are valid this cycle.
- `done` output 1: one-cycle pulse at the end of a pass.
- `i_count_out` output 4: row-major C index of `c_out`, i = r*M+c.

## Operation
- Storage: M*P registers, A[r][c] at address r*P+c. Writes are synchronous. The read path is combinational.
- Writes take effect only in IDLE, when `a_wen` is 1 and `a_addr` < M*P. All other writes are dropped.
- States and transitions:
  - IDLE → RUN when `start` is 1.
  - RUN → DONE after the element at index M*P-1 is emitted.
  - DONE → IDLE unconditionally.
- `start` is ignored in RUN and DONE.
- RUN walks i = 0..M*P-1, one element per cycle. For i: r = i / M, c = i % M, `c_out` = A[c*P + r], `i_count_out` = i.
- Results are data moves only, with no arithmetic. Sign is preserved bit-exactly.
- `done` is 1 only in DONE. `c_valid` is 1 only while an element is presented.
- Memory contents survive across passes. Back-to-back passes are allowed: `start` may be reasserted in the IDLE cycle right after DONE.

## Timing
- Reset (`rst` = 0) takes effect immediately, without waiting for a clock edge:
  - `c_out` = 0, `c_valid` = 0, `done` = 0, `i_count_out` = 0.
  - State returns to IDLE and all storage is cleared to 0.
- Reset mid-pass aborts the pass. No `done` is produced.
- All outputs are registered.
- If `start` is sampled at edge t:
  - Index 0 is presented (`c_valid` = 1) after edge t+1.
  - Index k is presented after edge t+1+k.
  - The last element (index M*P-1) is presented after edge t+M*P.
  - `done` is 1 for exactly one cycle after edge t+M*P+1, with `c_valid` = 0 in that cycle.
- Pass latency is M*P+1 cycles from the `start` edge to `done`.
- Consumers sample `c_out` and `i_count_out` on the rising edge where `c_valid` = 1. The final element is therefore captured before `done` is visible.
- A write on the same edge as `start` in IDLE is accepted and is visible to the pass.

## Configuration
- `MAT_TRANSPOSE_BUSY_EN` defined:
  - Adds output `busy` (1 bit), which is 1 in RUN and DONE and 0 in IDLE.
  - `busy` resets to 0.
- `MAT_TRANSPOSE_BUSY_EN` not defined:
  - The `busy` port is absent.
  - All other behaviour is identical.

## Structure
- Shared package `mat_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - `N_ELEM` = M*P;
  - the index width constant (4).
- One sub-module, `mat_regfile`: M*P × DATA_WIDTH storage with synchronous write, combinational read, and asynchronous clear.
- The FSM, the index counter and the transposed address generation stay in the top level.

## Test plan
- Load A = 1..9 row-major, pulse `start` → 9 valid beats; index 0..8 carry 1,4,7,2,5,8,3,6,9; `done` one cycle after beat 8.
- Load negative values (A[0] = -5, A[1] = 0x80000000), then transpose → C[0] = -5, C[3] = 0x80000000, sign bits intact.
- Assert `a_wen` with `a_addr` = 4 and data 99 during RUN, then run a second pass → the second pass still emits the original A[4] at index 4.
- Assert `rst` = 0 at beat 4 → outputs drop to 0 immediately, no `done`; a new `start` after release streams all zeros.
- Pulse `start` again during RUN and again in the IDLE cycle right after `done` → the mid-run pulse is ignored; the second pass begins with index 0 two edges later.
- Write to `a_addr` = 12 → no storage changes; the next pass output matches the prior contents.
